// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Serial transmitter for the message-generator chain. Each accepted request
// sends one frame on the line: a start bit (0), eight data bits LSB-first,
// then STOP_BITS stop bits (1). A one-cycle tx_done pulse marks the end of the
// frame so the generator can present its next character.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   tx_start    single-cycle request; tx_msg is captured in the same cycle
//   tx_msg      byte to transmit
//   tx          serial line, idles high (mark)
//   tx_busy     high while a frame is in progress
//   tx_done     one-cycle pulse at frame completion
//   tx_overrun  sticky: a tx_start arrived while busy; cleared only by rst
//
// Handshake: tx_start acts as "valid" and the idle FSM acts as "ready". A
// request is accepted only on a cycle where the FSM is in IDLE (tx_busy low);
// acceptance captures tx_msg. A request on any other cycle is dropped and
// raises tx_overrun. tx_done is the completion strobe; the FSM is already in
// IDLE during that cycle, so a request presented alongside tx_done starts the
// next frame immediately with no extra idle bit.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_msg,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'd7;
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shift_reg;

  wire bit_end = (baud_cnt == CNT_LAST);

  // tx is updated on the same edge as the state change, so the line level
  // always matches the state being entered and the output stays registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (tx_start && (state != S_IDLE)) begin
        tx_overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shift_reg <= tx_msg;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= shift_reg >> 1;
              // Next bit is presented now, ahead of the shift landing.
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Bench for uart_tx. Two instances: dut_a (CLKS_PER_BIT=4, STOP_BITS=1) and
// dut_b (CLKS_PER_BIT=4, STOP_BITS=2). Driver tasks apply requests and record
// one sample per cycle of {tx, tx_busy, tx_done, tx_overrun}; a frame-level
// reference model fills an expected queue that each test compares inline.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int N_A = (9 + 1) * CPB;
  localparam int N_B = (9 + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] msg_a, msg_b;
  logic       tx_a, busy_a, done_a, ovr_a;
  logic       tx_b, busy_b, done_b, ovr_b;

  int vectors    = 0;
  int miscompares = 0;

  logic       exp_ovr;        // model of dut_a's sticky overrun flag
  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_start(start_a), .tx_msg(msg_a),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a), .tx_overrun(ovr_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_start(start_b), .tx_msg(msg_b),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b), .tx_overrun(ovr_b)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Frame as a bit list: index 0 start, 1..8 data LSB-first, rest stop.
  // Cycle t after the accepting edge shows list entry t / cpb.
  function automatic logic model_frame(input logic [7:0] m, input int cpb,
                                       input int stop_bits, input int inj_t,
                                       input logic ovr_in);
    logic [9:0] fr;
    logic       ovr;
    logic       line;
    int         n;
    int         j;
    fr  = {1'b1, m, 1'b0};
    ovr = ovr_in;
    n   = (9 + stop_bits) * cpb;
    for (int t = 0; t < n; t++) begin
      j    = t / cpb;
      line = (j < 10) ? fr[j] : 1'b1;
      exp_q.push_back({line, 1'b1, 1'b0, ovr});
      if (t == inj_t) ovr = 1'b1;
    end
    exp_q.push_back({1'b1, 1'b0, 1'b1, ovr});
    return ovr;
  endfunction

  function automatic void model_idle(input int n, input logic ovr);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, ovr});
  endfunction

  // ---------------------------------------------------------------- drivers
  // Called between edges; presents the request for the next edge (E0), then
  // records the N frame cycles plus the tx_done cycle. Returns at the falling
  // edge of the tx_done cycle, so a following drive_a is a back-to-back start.
  task automatic drive_a(input logic [7:0] m, input int inj_t, input bit scramble);
    start_a = 1'b1;
    msg_a   = m;
    @(posedge clk); #1;
    for (int t = 0; t < N_A; t++) begin
      start_a = (t == inj_t);
      if (t == inj_t)    msg_a = 8'hFF;
      else if (scramble) msg_a = 8'($urandom_range(0, 255));
      else               msg_a = 8'h00;
      @(negedge clk);
      obs_q.push_back({tx_a, busy_a, done_a, ovr_a});
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    @(negedge clk);
    obs_q.push_back({tx_a, busy_a, done_a, ovr_a});
  endtask

  task automatic idle_a(input int n);
    start_a = 1'b0;
    repeat (n) begin
      @(negedge clk);
      obs_q.push_back({tx_a, busy_a, done_a, ovr_a});
    end
  endtask

  task automatic drive_b(input logic [7:0] m);
    start_b = 1'b1;
    msg_b   = m;
    @(posedge clk); #1;
    for (int t = 0; t < N_B; t++) begin
      start_b = 1'b0;
      msg_b   = 8'($urandom_range(0, 255));
      @(negedge clk);
      obs_q.push_back({tx_b, busy_b, done_b, ovr_b});
      @(posedge clk); #1;
    end
    @(negedge clk);
    obs_q.push_back({tx_b, busy_b, done_b, ovr_b});
  endtask

  task automatic idle_b(input int n);
    start_b = 1'b0;
    repeat (n) begin
      @(negedge clk);
      obs_q.push_back({tx_b, busy_b, done_b, ovr_b});
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    obs_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({tx_a, busy_a, done_a, ovr_a} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_a got %b want 1000", {tx_a, busy_a, done_a, ovr_a});
    end
    vectors++;
    if ({tx_b, busy_b, done_b, ovr_b} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_b got %b want 1000", {tx_b, busy_b, done_b, ovr_b});
    end
    @(negedge clk);
    rst = 1'b0;
    idle_a(3);
    model_idle(3, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_idle[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_frame();
    obs_q.delete(); exp_q.delete();
    drive_a(8'h52, -1, 1'b1);
    idle_a(2);
    exp_ovr = model_frame(8'h52, CPB, 1, -1, exp_ovr);
    model_idle(2, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_frame[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    drive_a(8'h52, -1, 1'b1);
    drive_a(8'h50, -1, 1'b1);
    idle_a(2);
    exp_ovr = model_frame(8'h52, CPB, 1, -1, exp_ovr);
    exp_ovr = model_frame(8'h50, CPB, 1, -1, exp_ovr);
    model_idle(2, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_msg_capture();
    obs_q.delete(); exp_q.delete();
    drive_a(8'h23, -1, 1'b0);
    idle_a(1);
    exp_ovr = model_frame(8'h23, CPB, 1, -1, exp_ovr);
    model_idle(1, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL msg_capture[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    obs_q.delete(); exp_q.delete();
    drive_a(8'h2D, 12, 1'b1);
    idle_a(4);
    exp_ovr = model_frame(8'h2D, CPB, 1, 12, exp_ovr);
    model_idle(4, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL overrun[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int gap;
    logic [7:0] m;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      m = 8'($urandom_range(0, 255));
      drive_a(m, -1, 1'b1);
      exp_ovr = model_frame(m, CPB, 1, -1, exp_ovr);
      gap = $urandom_range(0, 3);   // 0 gives a back-to-back start
      idle_a(gap);
      model_idle(gap, exp_ovr);
    end
    idle_a(2);
    model_idle(2, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    obs_q.delete(); exp_q.delete();
    start_a = 1'b1;
    msg_a   = 8'h52;
    @(posedge clk); #1;
    start_a = 1'b0;
    // Cycle 17 after acceptance lies inside data bit 3 (cycles 16..19).
    repeat (17) @(posedge clk);
    #2;
    vectors++;
    if (tx_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_bit3 got %b want 0", tx_a);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({tx_a, busy_a, done_a, ovr_a} !== 4'b1000) begin
      miscompares++;
      $display("FAIL midframe_reset got %b want 1000", {tx_a, busy_a, done_a, ovr_a});
    end
    exp_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_a(N_A + 4);
    model_idle(N_A + 4, exp_ovr);
    drive_a(8'h4D, -1, 1'b1);
    exp_ovr = model_frame(8'h4D, CPB, 1, -1, exp_ovr);
    idle_a(2);
    model_idle(2, exp_ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL after_reset[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_two_stop_bits();
    logic       ovr;
    logic [7:0] m;
    obs_q.delete(); exp_q.delete();
    m = 8'($urandom_range(0, 255));
    drive_b(8'h00);
    drive_b(m);
    idle_b(3);
    ovr = model_frame(8'h00, CPB, 2, -1, 1'b0);
    ovr = model_frame(m, CPB, 2, -1, ovr);
    model_idle(3, ovr);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL two_stop[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    msg_a   = 8'h00;
    msg_b   = 8'h00;
    exp_ovr = 1'b0;

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_msg_capture();
    test_overrun();
    test_random();
    test_reset_midframe();
    test_two_stop_bits();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
